vga_box_render: RTL and testbench
=================================

Name: vga_box_render

Overview:
- Pixel-generation stage directly downstream of the 800x600 SVGA sync generator.
- Consumes the pixel coordinates, display-enable and sync signals, and produces 4-bit-per-channel RGB.
- Draws a 32x32 box over a background with a screen border. Sync outputs are delayed to stay aligned with the colour pipeline.
- Box position updates once per frame. It either bounces on its own (AUTO) or follows buttons (MANUAL).

Parameters:
- SCREEN_WIDTH, 800, visible pixels per line
- SCREEN_HEIGHT, 600, visible lines per frame
- BOX_SIZE, 32, box edge length in pixels
- STEP, 4, box displacement in pixels per frame
- IDLE_FRAMES, 120, frames without a button press before MANUAL returns to AUTO

Ports:
- clk  in  1  pixel clock, same clock as the sync stage
- w_rst_n  in  1  asynchronous active-low reset
- pos_x  in  11  current pixel x from the sync stage
- pos_y  in  11  current pixel y from the sync stage
- video_on  in  1  high when the pixel is in the visible area (sync stage active output)
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- btn_left, btn_right, btn_up, btn_down  in  1 each  direction buttons, already synchronised and debounced, active-high
- pause  in  1  when high, box position and mode are frozen
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- hsync_out, vsync_out  out  1 each  sync delayed by 2 cycles
- frame_tick  out  1  one-cycle pulse at frame update

Behaviour:
- Reset (asynchronous assert, synchronous release), applied to all registers:
  - vga_r/g/b = 0; hsync_out = vsync_out = 1; frame_tick = 0.
  - box_x = 384, box_y = 284; dx = dy = +1; mode = AUTO; idle_cnt = 0.
- Frame tick:
  - vsync_in is registered into vs_d.
  - Tick condition: vs_d = 1 and vsync_in = 0 (falling edge).
  - In the cycle after the edge is sampled, frame_tick = 1 for exactly one cycle.
  - On that same clock edge, the position, direction and mode registers load their new values.
- pause = 1 at a tick: frame_tick still pulses; box_x, box_y, dx, dy, mode and idle_cnt are unchanged.
- Mode FSM (evaluated on tick only):
  - AUTO -> MANUAL when any button is high. That frame's move already uses the MANUAL rules.
  - MANUAL, no button high: idle_cnt increments. When idle_cnt reaches IDLE_FRAMES-1, go to AUTO and clear idle_cnt.
  - MANUAL, any button high: idle_cnt = 0.
- AUTO move, x axis (y axis identical with box_y/dy/SCREEN_HEIGHT). Let maxx = SCREEN_WIDTH-BOX_SIZE.
  - dx = +1 and box_x+STEP >= maxx: box_x = maxx, dx = -1.
  - dx = -1 and box_x <= STEP: box_x = 0, dx = +1.
  - Otherwise box_x moves by STEP in the direction of dx.
- MANUAL move:
  - Each pressed button moves the box STEP in its direction, clamped to [0, maxx] or [0, maxy]; dx/dy unchanged.
  - Opposing buttons pressed together cancel: no move on that axis.
- Arithmetic: 12-bit intermediates so clamps never wrap.
- Colour pipeline, latency 2 cycles from pos_x/pos_y/video_on to vga_*:
  - Stage 1 registers: in_box = box_x <= pos_x < box_x+BOX_SIZE and box_y <= pos_y < box_y+BOX_SIZE; on_border = pos_x==0 or pos_x==SCREEN_WIDTH-1 or pos_y==0 or pos_y==SCREEN_HEIGHT-1; video_on.
  - Stage 2 registers the colour. Priority, first match wins:
    - !video_on -> 000
    - in_box -> FFF in AUTO, F00 in MANUAL
    - on_border -> 0F0
    - background -> 004
- hsync_out/vsync_out: hsync_in/vsync_in through two flops, so sync and colour stay aligned.
- A position update mid-frame (tick only at vsync) cannot occur, so there is no tearing within a frame.

Optional Feature:
- Macro: VGA_GRID_EN.
- Defined: background pixels where pos_x[5:0]==0 or pos_y[5:0]==0 are 888 (grid every 64 px). Priority is below border, above background.
- Undefined: no grid logic; background is solid 004.

Test Plan:
- Reset held low 5 cycles, then released:
  - During reset: vga_* = 000, hsync_out = vsync_out = 1.
  - After the first tick: box_x=388, box_y=288, frame_tick high for exactly 1 cycle.
- Pixel (384,284) with video_on = 1 after reset, no tick yet: vga = FFF two cycles later. Pixel (416,284): 004. Pixel (0,10): 0F0. video_on = 0: 000.
- AUTO bounce, box_x=764 with dx=+1, one tick: box_x=768, dx=-1. Next tick: box_x=764.
- btn_left held across 3 ticks from box_x=8:
  - Positions 4, 0, 0; mode goes to MANUAL; in-box pixel colour F00.
  - Release buttons: after 120 ticks mode is AUTO and box colour is FFF.
- pause=1 across 2 ticks: frame_tick pulses twice; box_x, box_y and mode unchanged.
- Apply a hsync_in pulse: hsync_out shows the same pulse delayed 2 cycles. With VGA_GRID_EN defined, pixel (64,100) = 888; without it, 004.

Source files
------------

// File: rtl/vga_box_render.sv
// vga_box_render: draws a bouncing/button-driven 32x32 box over a bordered background for 800x600 SVGA; optional grid via VGA_GRID_EN
module vga_box_render #(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BOX_SIZE      = 32,
  parameter int STEP          = 4,
  parameter int IDLE_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        w_rst_n,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        pause,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);
  localparam int IW = $clog2(IDLE_FRAMES);
  localparam logic [11:0] STP = 12'(STEP);
  localparam logic [11:0] BSZ = 12'(BOX_SIZE);
  localparam logic [11:0] MAXX = 12'(SCREEN_WIDTH - BOX_SIZE);
  localparam logic [11:0] MAXY = 12'(SCREEN_HEIGHT - BOX_SIZE);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_FRAMES - 1);
  typedef enum logic {AUTO, MANUAL} mode_t;
  mode_t mode;
  logic [10:0] box_x, box_y;
  logic dx, dy;
  logic [IW-1:0] idle_cnt;
  logic vs_d, tick, any_btn, manual;
  logic [11:0] x12, y12, px12, py12, nx, ny;
  logic ndx, ndy;
  logic in_box_q, border_q, von_q;
  logic [11:0] rgb_q, bg, colour;
  logic [1:0] hs_q, vs_q;
  assign tick = vs_d & ~vsync_in;
  assign any_btn = btn_left | btn_right | btn_up | btn_down;
  assign manual = any_btn | (mode == MANUAL);
  assign x12 = {1'b0, box_x};
  assign y12 = {1'b0, box_y};
  assign px12 = {1'b0, pos_x};
  assign py12 = {1'b0, pos_y};
  // next box position/direction; manual moves clamp, auto moves bounce off the edges
  always_comb begin
    nx = x12;
    ny = y12;
    ndx = dx;
    ndy = dy;
    if (manual) begin
      if (btn_left & ~btn_right) nx = (x12 >= STP) ? x12 - STP : 12'd0;
      else if (btn_right & ~btn_left) nx = (x12 + STP > MAXX) ? MAXX : x12 + STP;
      if (btn_up & ~btn_down) ny = (y12 >= STP) ? y12 - STP : 12'd0;
      else if (btn_down & ~btn_up) ny = (y12 + STP > MAXY) ? MAXY : y12 + STP;
    end else begin
      if (dx) begin
        nx = (x12 + STP >= MAXX) ? MAXX : x12 + STP;
        ndx = ~(x12 + STP >= MAXX);
      end else begin
        nx = (x12 <= STP) ? 12'd0 : x12 - STP;
        ndx = (x12 <= STP);
      end
      if (dy) begin
        ny = (y12 + STP >= MAXY) ? MAXY : y12 + STP;
        ndy = ~(y12 + STP >= MAXY);
      end else begin
        ny = (y12 <= STP) ? 12'd0 : y12 - STP;
        ndy = (y12 <= STP);
      end
    end
  end
  // frame tick detection plus once-per-frame position and mode update
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      vs_d <= 1'b1;
      frame_tick <= 1'b0;
      box_x <= 11'd384;
      box_y <= 11'd284;
      dx <= 1'b1;
      dy <= 1'b1;
      mode <= AUTO;
      idle_cnt <= '0;
    end else begin
      vs_d <= vsync_in;
      frame_tick <= tick;
      if (tick && !pause) begin
        box_x <= nx[10:0];
        box_y <= ny[10:0];
        dx <= ndx;
        dy <= ndy;
        if (any_btn) begin
          mode <= MANUAL;
          idle_cnt <= '0;
        end else if (mode == MANUAL) begin
          mode <= (idle_cnt == IDLE_LAST) ? AUTO : MANUAL;
          idle_cnt <= (idle_cnt == IDLE_LAST) ? '0 : idle_cnt + 1'b1;
        end
      end
    end
  end
`ifdef VGA_GRID_EN
  logic grid_q;
  assign bg = grid_q ? 12'h888 : 12'h004;
  // grid classification registered alongside the other stage-1 flags
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) grid_q <= 1'b0;
    else grid_q <= (pos_x[5:0] == 6'd0) || (pos_y[5:0] == 6'd0);
  end
`else
  assign bg = 12'h004;
`endif
  assign colour = !von_q ? 12'h000 :
                  in_box_q ? ((mode == MANUAL) ? 12'hF00 : 12'hFFF) :
                  border_q ? 12'h0F0 : bg;
  // two-stage colour pipeline with sync delayed to match
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      in_box_q <= 1'b0;
      border_q <= 1'b0;
      von_q <= 1'b0;
      rgb_q <= 12'h000;
      hs_q <= 2'b11;
      vs_q <= 2'b11;
    end else begin
      in_box_q <= (px12 >= x12) && (px12 < x12 + BSZ) && (py12 >= y12) && (py12 < y12 + BSZ);
      border_q <= (pos_x == 11'd0) || (pos_x == 11'(SCREEN_WIDTH - 1)) ||
                  (pos_y == 11'd0) || (pos_y == 11'(SCREEN_HEIGHT - 1));
      von_q <= video_on;
      rgb_q <= colour;
      hs_q <= {hs_q[0], hsync_in};
      vs_q <= {vs_q[0], vsync_in};
    end
  end
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign hsync_out = hs_q[1];
  assign vsync_out = vs_q[1];
endmodule

// File: tb/tb_vga_box_render.sv
// tb_vga_box_render: directed scoreboard bench for vga_box_render
module tb_vga_box_render;
  logic clk = 1'b0, w_rst_n = 1'b0;
  logic [10:0] pos_x = '0, pos_y = '0;
  logic video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, pause = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic hsync_out, vsync_out, frame_tick;
  int checks = 0, failures = 0;
  logic [11:0] q[$];
  int mx = 384, my = 284, mi = 0;
  bit mdx = 1, mdy = 1, mm = 0;
  vga_box_render dut (
    .clk(clk), .w_rst_n(w_rst_n), .pos_x(pos_x), .pos_y(pos_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .pause(pause), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pix(input string tag, input int x, input int y, input logic von, input logic [11:0] exp);
    pos_x = 11'(x);
    pos_y = 11'(y);
    video_on = von;
    q.push_back(exp);
    repeat (2) @(posedge clk);
    #1;
    chk(tag, {vga_r, vga_g, vga_b}, q.pop_front());
  endtask
  task automatic tick();
    bit any;
    vsync_in = 1'b0;
    @(posedge clk);
    #1;
    chk("frame_tick_hi", {11'd0, frame_tick}, 12'd1);
    any = btn_left | btn_right | btn_up | btn_down;
    if (!pause) begin
      if (any || mm) begin
        if (btn_left && !btn_right) mx = (mx >= 4) ? mx - 4 : 0;
        if (btn_right && !btn_left) mx = (mx + 4 > 768) ? 768 : mx + 4;
        if (btn_up && !btn_down) my = (my >= 4) ? my - 4 : 0;
        if (btn_down && !btn_up) my = (my + 4 > 568) ? 568 : my + 4;
      end else begin
        if (mdx) begin if (mx + 4 >= 768) begin mx = 768; mdx = 0; end else mx += 4; end
        else begin if (mx <= 4) begin mx = 0; mdx = 1; end else mx -= 4; end
        if (mdy) begin if (my + 4 >= 568) begin my = 568; mdy = 0; end else my += 4; end
        else begin if (my <= 4) begin my = 0; mdy = 1; end else my -= 4; end
      end
      if (any) begin mm = 1; mi = 0; end
      else if (mm) begin if (mi == 119) begin mm = 0; mi = 0; end else mi++; end
    end
    @(posedge clk);
    #1;
    chk("frame_tick_lo", {11'd0, frame_tick}, 12'd0);
    vsync_in = 1'b1;
    @(posedge clk);
    #1;
    chk("box_x", 12'(dut.box_x), 12'(mx));
    chk("box_y", 12'(dut.box_y), 12'(my));
    chk("mode", 12'(dut.mode), 12'(mm));
  endtask
  initial begin
    int sx, sy;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_hsync", {11'd0, hsync_out}, 12'd1);
    chk("rst_vsync", {11'd0, vsync_out}, 12'd1);
    chk("rst_tick", {11'd0, frame_tick}, 12'd0);
    w_rst_n = 1'b1;
    @(posedge clk);
    #1;
    pix("box_auto", 384, 284, 1'b1, 12'hFFF);
    pix("right_of_box", 416, 284, 1'b1, 12'h004);
    pix("border", 0, 10, 1'b1, 12'h0F0);
    pix("blank", 384, 284, 1'b0, 12'h000);
    tick();
    chk("first_x", 12'(dut.box_x), 12'd388);
    chk("first_y", 12'(dut.box_y), 12'd288);
    for (int i = 0; i < 94; i++) tick();
    chk("pre_bounce_x", 12'(dut.box_x), 12'd764);
    tick();
    chk("bounce_x", 12'(dut.box_x), 12'd768);
    tick();
    chk("after_bounce_x", 12'(dut.box_x), 12'd764);
    for (int i = 0; i < 189; i++) tick();
    chk("at_8", 12'(dut.box_x), 12'd8);
    btn_left = 1'b1;
    tick();
    chk("left_1", 12'(dut.box_x), 12'd4);
    tick();
    chk("left_2", 12'(dut.box_x), 12'd0);
    tick();
    chk("left_3", 12'(dut.box_x), 12'd0);
    chk("manual_mode", 12'(dut.mode), 12'd1);
    pix("manual_box", mx + 2, my + 2, 1'b1, 12'hF00);
    btn_left = 1'b0;
    for (int i = 0; i < 120; i++) tick();
    chk("auto_again", 12'(dut.mode), 12'd0);
    pix("auto_box", mx + 2, my + 2, 1'b1, 12'hFFF);
    sx = mx;
    sy = my;
    pause = 1'b1;
    btn_right = 1'b1;
    tick();
    tick();
    chk("pause_x", 12'(dut.box_x), 12'(sx));
    chk("pause_y", 12'(dut.box_y), 12'(sy));
    chk("pause_mode", 12'(dut.mode), 12'd0);
    pause = 1'b0;
    btn_right = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hsync_in = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
      q.push_back({11'd0, hsync_in});
      @(posedge clk);
      #1;
      if (q.size() >= 2) chk("hsync_delay", {11'd0, hsync_out}, q.pop_front());
    end
    q.delete();
`ifdef VGA_GRID_EN
    pix("grid", 64, 100, 1'b1, 12'h888);
`else
    pix("grid", 64, 100, 1'b1, 12'h004);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
